// File: rtl/i2c_reg_seq.sv
// Register-access sequencer driving a byte-level I2C master: turns one read/write request into the byte stream.
// Optional per-byte WAIT_XFER timeout is enabled with `define I2C_SEQ_TIMEOUT_EN.
module i2c_reg_seq #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rnw,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_reg,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic [1:0] rsp_err,
    output logic [7:0] m_data,
    output logic       m_wr,
    output logic       m_rd,
    output logic       m_dirsend,
    output logic       m_resendstart,
    input  logic       m_buffempty,
    input  logic       m_chartransferred,
    input  logic       m_ack,
    input  logic [7:0] m_dataout,
    input  logic       m_arblost
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        WAIT_XFER,
        ACKCHK,
        DONE
    } state_t;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_NACK    = 2'b01;
    localparam logic [1:0] ERR_ARBLOST = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    state_t     state, state_nxt;
    logic [1:0] idx, idx_nxt;
    logic [1:0] err_nxt;
    logic [7:0] rdata_nxt;
    logic [7:0] data_nxt;
    logic [1:0] last_idx;
    logic       busy;

    logic       rnw_q;
    logic [6:0] addr_q;
    logic [7:0] reg_q;
    logic [7:0] wdata_q;

    // Byte on the wire for a given position of the write or read sequence.
    function automatic logic [7:0] seq_byte(input logic       rnw,
                                            input logic [1:0] i,
                                            input logic [6:0] addr,
                                            input logic [7:0] regi,
                                            input logic [7:0] wdata);
        logic [7:0] b;
        case (i)
            2'd0:    b = {addr, 1'b0};
            2'd1:    b = regi;
            2'd2:    b = rnw ? {addr, 1'b1} : wdata;
            default: b = 8'hFF;
        endcase
        return b;
    endfunction

`ifdef I2C_SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    // Abort on the cycle whose increment would make the count reach TIMEOUT_CYCLES-1.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 2);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     cnt <= '0;
        else if (state != WAIT_XFER) cnt <= '0;
        else                         cnt <= cnt + CNT_W'(1);
    end
`endif

    always_ff @(posedge clk) begin
        if (state == IDLE && req_valid) begin
            rnw_q   <= req_rnw;
            addr_q  <= req_addr;
            reg_q   <= req_reg;
            wdata_q <= req_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= 2'd0;
            rsp_err   <= ERR_OK;
            rsp_rdata <= 8'h00;
            m_data    <= 8'h00;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            rsp_err   <= err_nxt;
            rsp_rdata <= rdata_nxt;
            m_data    <= data_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        err_nxt       = rsp_err;
        rdata_nxt     = rsp_rdata;
        data_nxt      = m_data;
        last_idx      = rnw_q ? 2'd3 : 2'd2;
        busy          = (state != IDLE) && (state != DONE);
        req_ready     = (state == IDLE);
        rsp_valid     = (state == DONE);
        m_wr          = (state == STROBE);
        m_rd          = (state == ACKCHK);
        m_resendstart = (state == STROBE) && rnw_q && (idx == 2'd2);
        m_dirsend     = !(busy && rnw_q && (idx == 2'd3));

        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_nxt = SETUP;
                    idx_nxt   = 2'd0;
                    err_nxt   = ERR_OK;
                    data_nxt  = {req_addr, 1'b0};
                end
            end
            SETUP: begin
                if (m_buffempty) state_nxt = STROBE;
            end
            STROBE: begin
                state_nxt = WAIT_XFER;
            end
            WAIT_XFER: begin
                if (m_chartransferred) begin
                    state_nxt = ACKCHK;
`ifdef I2C_SEQ_TIMEOUT_EN
                end else if (cnt == TO_LAST) begin
                    state_nxt = DONE;
                    err_nxt   = ERR_TIMEOUT;
`endif
                end
            end
            ACKCHK: begin
                if (rnw_q && idx == 2'd3) begin
                    // Final read byte: master NACKs it, so m_ack carries no meaning here.
                    state_nxt = DONE;
                    rdata_nxt = m_dataout;
                end else if (m_ack) begin
                    state_nxt = DONE;
                    err_nxt   = ERR_NACK;
                end else if (idx == last_idx) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = SETUP;
                    idx_nxt   = idx + 2'd1;
                    data_nxt  = seq_byte(rnw_q, idx + 2'd1, addr_q, reg_q, wdata_q);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Arbitration loss overrides every other outcome, including a coincident NACK.
        if (busy && m_arblost) begin
            state_nxt = DONE;
            err_nxt   = ERR_ARBLOST;
            idx_nxt   = idx;
            rdata_nxt = rsp_rdata;
            data_nxt  = m_data;
        end
    end

endmodule

// File: doc/i2c_reg_seq.md
I2C_REG_SEQ -- requirements
Module: i2c_reg_seq

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 4096, meaning the maximum clk cycles spent in WAIT_XFER per byte before abort.
REQ-002 SHALL have ports clk input 1, the rising-edge clock; rst input 1, asynchronous active-high reset.
REQ-003 SHALL have port req_valid input 1, transaction request.
REQ-004 SHALL have port req_ready output 1, high only in IDLE.
REQ-005 SHALL have ports req_rnw input 1 (1=read), req_addr input 7 (slave address), req_reg input 8 (register index), req_wdata input 8 (write data).
REQ-006 SHALL have ports rsp_valid output 1 (one-cycle completion pulse), rsp_rdata output 8, rsp_err output 2 (00 ok, 01 NACK, 10 arbitration lost, 11 timeout).
REQ-007 SHALL have ports m_data output 8, m_wr output 1, m_rd output 1, m_dirsend output 1 and m_resendstart output 1, all driving the downstream byte-level I2C master.
REQ-008 SHALL have ports m_buffempty input 1, m_chartransferred input 1, m_ack input 1 (0=ACK), m_dataout input 8 and m_arblost input 1, all from the master.

Function
REQ-009 SHALL implement states IDLE, SETUP, STROBE, WAIT_XFER, ACKCHK and DONE.
REQ-010 IDLE: when req_valid=1, SHALL latch all req_* fields, clear the byte index to 0, and go to SETUP.
REQ-011 Write sequence SHALL be bytes {addr,0}, reg, wdata (index 0..2).
REQ-012 Read sequence SHALL be bytes {addr,0}, reg, {addr,1}, 8'hFF (index 0..3).
REQ-013 For read index 3, m_dirsend SHALL be 0; in all other cases m_dirsend SHALL be 1.
REQ-014 SETUP: SHALL drive m_data and m_dirsend for the current index, and wait until m_buffempty=1 before going to STROBE.
REQ-015 STROBE: SHALL assert m_wr for exactly one cycle, with m_data held stable one cycle before and during the pulse, then go to WAIT_XFER.
REQ-016 For read index 2, SHALL pulse m_resendstart for one cycle in the same cycle m_wr pulses.
REQ-017 WAIT_XFER: SHALL wait for m_chartransferred=1, then go to ACKCHK.
REQ-018 ACKCHK: SHALL pulse m_rd for one cycle and sample m_ack and m_dataout in that cycle.
REQ-019 In ACKCHK, if the index is the last index, SHALL go to DONE; otherwise it SHALL increment the index and return to SETUP.
REQ-020 At ACKCHK of read index 3, SHALL store m_dataout in rsp_rdata; m_ack for that byte SHALL be ignored (master NACK).
REQ-021 At ACKCHK of any other index, m_ack=1 SHALL abort the sequence with rsp_err=01 and go to DONE without pushing further bytes, so the master issues STOP.
REQ-022 m_arblost=1 in any non-IDLE state SHALL abort the sequence with rsp_err=10 and go to DONE; when arbitration loss coincides with NACK, arbitration loss SHALL win.
REQ-023 DONE: SHALL pulse rsp_valid for one cycle with rsp_err and rsp_rdata stable, then go to IDLE.
REQ-024 rsp_rdata SHALL hold its value until the next read completes; on write or error it SHALL be unchanged.
REQ-025 req_valid SHALL be ignored whenever the block is not in IDLE.
REQ-026 Back-to-back requests SHALL be allowed, with req_ready high in the cycle after DONE.

Reset
REQ-027 rst SHALL force IDLE with req_ready=1, rsp_valid=0, rsp_err=00, rsp_rdata=8'h00, m_data=8'h00, m_wr=0, m_rd=0, m_dirsend=1, m_resendstart=0, index=0, and the timeout counter=0.
REQ-028 rst mid-transaction SHALL discard the transaction with no rsp_valid.

Configuration
REQ-029 With I2C_SEQ_TIMEOUT_EN defined, a counter SHALL clear on entering WAIT_XFER and increment each cycle in that state.
REQ-030 With I2C_SEQ_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES-1 while waiting SHALL abort the sequence with rsp_err=11 and go to DONE.
REQ-031 Without I2C_SEQ_TIMEOUT_EN, the counter SHALL be absent, WAIT_XFER SHALL wait indefinitely, and rsp_err SHALL never be 11.

Verification
REQ-032 Write addr=0x50, reg=0x10, wdata=0xA5, with the master model ACKing all bytes -> m_data sequence 0xA0, 0x10, 0xA5; three m_wr pulses; rsp_valid with rsp_err=00.
REQ-033 Read addr=0x50, reg=0x20, with the model returning 0x3C -> m_data 0xA0, 0x20, 0xA1, 0xFF; m_resendstart coincides with the third m_wr; m_dirsend=0 on the fourth byte; rsp_rdata=0x3C with rsp_err=00.
REQ-034 Write where the model NACKs byte 1 -> exactly two m_wr pulses; rsp_err=01; rsp_rdata unchanged.
REQ-035 m_arblost asserted during byte 0 of a read -> no further m_wr; rsp_err=10; next req_valid is accepted.
REQ-036 With I2C_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=16, m_chartransferred never asserts -> rsp_valid 16 cycles after the m_wr pulse with rsp_err=11.
REQ-037 rst asserted in WAIT_XFER -> all outputs reach reset values immediately, with no rsp_valid.
